imem_loader: RTL and testbench

Instruction-memory front end that sits directly upstream of the 16-bit pipeline CPU.
- Receives a program image as a byte stream (valid/ready) and assembles 16-bit words into a 256x16 instruction RAM.
- Verifies the image with a checksum, then releases the CPU via enable/start.
- Serves the CPU's fetch port combinationally, because the CPU latches i_datain in the same cycle it drives i_addr.

---
 rtl/imem_pkg.sv | 27 ++
 rtl/imem_ram.sv | 33 +++
 rtl/imem_loader.sv | 158 +++++++++++++++
 tb/tb_imem_loader.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : imem_pkg
// Description : Shared types and constants for the instruction-memory loader.
// Revision    : 1.0 - initial release
// ============================================================================
package imem_pkg;

  typedef logic [7:0]  byte_t;
  typedef logic [15:0] word_t;

  // Framing FSM states
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LEN  = 3'd1,
    S_HI   = 3'd2,
    S_LO   = 3'd3,
    S_CSUM = 3'd4,
    S_RUN  = 3'd5,
    S_ERR  = 3'd6
  } state_t;

  // Default frame header byte
  localparam byte_t HDR_DEFAULT = 8'hA5;

endpackage : imem_pkg
`default_nettype wire

// File: rtl/imem_ram.sv
`default_nettype none
// ============================================================================
// Module      : imem_ram
// Description : 2**ADDR_W x DATA_W instruction RAM, one synchronous write
//               port and one asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_ram #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 16
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // Write port: a word lands on the edge that accepts its low byte
  always_ff @(posedge clock) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read port is combinational so the CPU sees data in its fetch cycle
  assign rdata = mem[raddr];

endmodule : imem_ram
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : imem_loader
// Description : Receives a framed byte stream (HDR, LEN, 2*N data bytes,
//               CSUM), assembles 16-bit words into instruction RAM, verifies
//               the XOR checksum and releases the CPU. Serves the CPU fetch
//               port combinationally.
// Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
  import imem_pkg::*;
#(
  parameter int    ADDR_W = 8,
  parameter int    DATA_W = 16,
  parameter byte_t HDR    = HDR_DEFAULT
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [DATA_W-1:0] i_datain,
  output logic              cpu_enable,
  output logic              cpu_start,
  output logic              load_done,
  output logic              load_err,
  output logic [ADDR_W:0]   word_count
);

  localparam int CNT_W = ADDR_W + 1;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    n_q, n_d;
  logic [CNT_W-1:0]    word_count_q, word_count_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  byte_t               csum_q, csum_d;
  byte_t               hi_q, hi_d;
  logic                cpu_start_q, cpu_start_d;
  logic                load_done_q, load_done_d;
  logic                load_err_q, load_err_d;

  logic                accept;
  logic                we;
  logic [DATA_W-1:0]   wdata;

  // The block can take a byte every cycle except while held in reset
  assign rx_ready = ~reset;
  assign accept   = rx_valid & rx_ready;

  assign wdata    = {hi_q, rx_data};

  // Next-state, checksum, counter and RAM-write logic; only accepted bytes advance
  always_comb begin
    state_d      = state_q;
    n_d          = n_q;
    word_count_d = word_count_q;
    wr_addr_d    = wr_addr_q;
    csum_d       = csum_q;
    hi_d         = hi_q;
    cpu_start_d  = 1'b0;
    load_done_d  = load_done_q;
    load_err_d   = load_err_q;
    we           = 1'b0;

    if (accept) begin
      unique case (state_q)
        S_IDLE, S_RUN, S_ERR: begin
          // Header restarts a load from any idle-like state; other bytes drop
          if (rx_data == HDR) begin
            state_d = S_LEN;
          end
        end
        S_LEN: begin
          // LEN of zero encodes a full 256-word image
          n_d          = (rx_data == 8'h00) ? CNT_W'(256) : CNT_W'(rx_data);
          csum_d       = rx_data;
          wr_addr_d    = '0;
          word_count_d = '0;
          load_done_d  = 1'b0;
          load_err_d   = 1'b0;
          state_d      = S_HI;
        end
        S_HI: begin
          hi_d    = rx_data;
          csum_d  = csum_q ^ rx_data;
          state_d = S_LO;
        end
        S_LO: begin
          we           = 1'b1;
          wr_addr_d    = wr_addr_q + 1'b1;
          word_count_d = word_count_q + 1'b1;
          csum_d       = csum_q ^ rx_data;
          state_d      = ((word_count_q + 1'b1) == n_q) ? S_CSUM : S_HI;
        end
        S_CSUM: begin
          if (rx_data == csum_q) begin
            load_done_d = 1'b1;
            cpu_start_d = 1'b1;
            state_d     = S_RUN;
          end else begin
            load_err_d  = 1'b1;
            state_d     = S_ERR;
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      n_q          <= '0;
      word_count_q <= '0;
      wr_addr_q    <= '0;
      csum_q       <= '0;
      hi_q         <= '0;
      cpu_start_q  <= 1'b0;
      load_done_q  <= 1'b0;
      load_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      n_q          <= n_d;
      word_count_q <= word_count_d;
      wr_addr_q    <= wr_addr_d;
      csum_q       <= csum_d;
      hi_q         <= hi_d;
      cpu_start_q  <= cpu_start_d;
      load_done_q  <= load_done_d;
      load_err_q   <= load_err_d;
    end
  end

  // CPU runs only from RUN, so a reload header drops enable on its accepting edge
  assign cpu_enable = (state_q == S_RUN);
  assign cpu_start  = cpu_start_q;
  assign load_done  = load_done_q;
  assign load_err   = load_err_q;
  assign word_count = word_count_q;

  imem_ram #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_ram (
    .clock (clock),
    .we    (we),
    .waddr (wr_addr_q),
    .wdata (wdata),
    .raddr (i_addr),
    .rdata (i_datain)
  );

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_imem_loader
// Description : Directed self-checking bench for imem_loader.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

  logic        clock;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        rx_ready;
  logic [7:0]  i_addr;
  logic [15:0] i_datain;
  logic        cpu_enable;
  logic        cpu_start;
  logic        load_done;
  logic        load_err;
  logic [8:0]  word_count;

  int tests_run;
  int tests_failed;

  imem_loader #(
    .ADDR_W (8),
    .DATA_W (16),
    .HDR    (8'hA5)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .rx_valid   (rx_valid),
    .rx_data    (rx_data),
    .rx_ready   (rx_ready),
    .i_addr     (i_addr),
    .i_datain   (i_datain),
    .cpu_enable (cpu_enable),
    .cpu_start  (cpu_start),
    .load_done  (load_done),
    .load_err   (load_err),
    .word_count (word_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    if (obs !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // One byte, accepted on the next rising edge; returns 1 ns after it
  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(posedge clock);
    #1;
    rx_valid = 1'b0;
  endtask

  task automatic send_gap(input logic [7:0] b);
    send_byte(b);
    repeat (3) @(posedge clock);
    #1;
  endtask

  task automatic read_mem(input logic [7:0] a, output logic [15:0] d);
    i_addr = a;
    #1;
    d = i_datain;
  endtask

  logic [15:0] rd;

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    i_addr   = 8'h00;

    // ---------------- reset state ----------------
    repeat (2) @(posedge clock);
    #1;
    check("rst_rx_ready", rx_ready, 0);
    check("rst_word_count", word_count, 0);
    check("rst_flags", {cpu_enable, cpu_start, load_done, load_err}, 4'b0000);
    reset = 1'b0;
    #1;
    check("rx_ready_after_rst", rx_ready, 1);

    // ---------------- basic 2-word frame ----------------
    // CSUM = 02^48^05^4A^00 = 05
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h48); send_byte(8'h05);
    send_byte(8'h4A); send_byte(8'h00);
    check("f1_no_start_before_csum", cpu_start, 0);
    check("f1_enable_before_csum", cpu_enable, 0);
    send_byte(8'h05);
    check("f1_done", load_done, 1);
    check("f1_err", load_err, 0);
    check("f1_start_pulse", cpu_start, 1);
    check("f1_enable", cpu_enable, 1);
    check("f1_word_count", word_count, 2);
    @(posedge clock); #1;
    check("f1_start_one_cycle", cpu_start, 0);
    check("f1_enable_held", cpu_enable, 1);
    read_mem(8'd0, rd); check("f1_mem0", rd, 16'h4805);
    read_mem(8'd1, rd); check("f1_mem1", rd, 16'h4A00);

    // ---------------- reload from RUN ----------------
    send_byte(8'hA5);
    check("reload_enable_drop", cpu_enable, 0);
    check("reload_done_held", load_done, 1);
    send_byte(8'h01);
    check("reload_done_cleared", load_done, 0);
    send_byte(8'h12); send_byte(8'h34);
    send_byte(8'h27);  // 01^12^34
    check("reload_done", load_done, 1);
    check("reload_wc", word_count, 1);
    read_mem(8'd0, rd); check("reload_mem0", rd, 16'h1234);
    read_mem(8'd1, rd); check("reload_mem1_kept", rd, 16'h4A00);

    // ---------------- bad checksum ----------------
    send_byte(8'hA5); send_byte(8'h02);
    send_byte(8'h48); send_byte(8'h05);
    send_byte(8'h4A); send_byte(8'h00);
    send_byte(8'hFF);
    check("bad_err", load_err, 1);
    check("bad_done", load_done, 0);
    check("bad_enable", cpu_enable, 0);
    check("bad_no_start", cpu_start, 0);
    @(posedge clock); #1;
    check("bad_no_start_later", cpu_start, 0);
    check("bad_enable_later", cpu_enable, 0);

    // ---------------- gapped stream with leading junk ----------------
    // Checksum of LEN=01, data 08 00 is 01^08^00 = 09
    send_gap(8'h00);
    send_gap(8'h13);
    check("junk_err_held", load_err, 1);
    send_gap(8'hA5);
    send_gap(8'h01);
    check("gap_err_cleared", load_err, 0);
    check("gap_enable_off", cpu_enable, 0);
    send_gap(8'h08);
    send_gap(8'h00);
    check("gap_wc", word_count, 1);
    check("gap_not_done_yet", load_done, 0);
    send_byte(8'h09);
    check("gap_done", load_done, 1);
    check("gap_start", cpu_start, 1);
    read_mem(8'd0, rd); check("gap_mem0", rd, 16'h0800);

    // ---------------- full 256-word image (LEN=0) ----------------
    // XOR of 0..255 is 0, so CSUM = 00
    send_byte(8'hA5); send_byte(8'h00);
    for (int k = 0; k < 256; k++) begin
      send_byte(8'h00);
      send_byte(k[7:0]);
    end
    check("full_wc_before_csum", word_count, 9'd256);
    check("full_not_done_yet", load_done, 0);
    send_byte(8'h00);
    check("full_done", load_done, 1);
    check("full_err", load_err, 0);
    check("full_wc", word_count, 9'd256);
    read_mem(8'd255, rd); check("full_mem255", rd, 16'h00FF);
    read_mem(8'd0,   rd); check("full_mem0",   rd, 16'h0000);
    read_mem(8'd128, rd); check("full_mem128", rd, 16'h0080);

    // ---------------- reset mid-frame ----------------
    send_byte(8'hA5); send_byte(8'h04);
    send_byte(8'hAB); send_byte(8'hCD); send_byte(8'hEF);
    check("mid_wc", word_count, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_ready", rx_ready, 0);
    @(posedge clock); #1;
    check("mid_rst_wc", word_count, 0);
    check("mid_rst_flags", {cpu_enable, cpu_start, load_done, load_err}, 4'b0000);
    reset = 1'b0;
    read_mem(8'd0, rd); check("mid_mem0_kept", rd, 16'hABCD);
    // A stray data byte after reset must be ignored in IDLE
    send_byte(8'h11);
    check("mid_idle_wc", word_count, 0);
    send_byte(8'hA5); send_byte(8'h01);
    send_byte(8'h55); send_byte(8'h66);
    send_byte(8'h32);  // 01^55^66
    check("post_rst_done", load_done, 1);
    check("post_rst_enable", cpu_enable, 1);
    read_mem(8'd0, rd); check("post_rst_mem0", rd, 16'h5566);
    read_mem(8'd1, rd); check("post_rst_mem1", rd, 16'h0001);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_imem_loader
`default_nettype wire
